// File: rtl/huffman_row_scheduler.sv
// huffman_row_scheduler
//   Merges the per-row Huffman block streams of one frame into a single
//   output stream. Pops exactly one complete block from each row in strict
//   round-robin order (row 0..ROW-1, repeated blocks_per_row times), tags
//   the first word with sop and the last word with eop, and drives a
//   registered valid/ready output stage.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             one-cycle frame start pulse (honoured in IDLE only)
//   blocks_per_row    blocks each row contributes; sampled on accepted start
//   ch_empty/data/last  show-ahead FIFO heads, one per row
//   ch_rd             per-row pop strobe, one-hot or zero
//   out_valid/ready   output handshake
//   out_data/last/sop/eop  output word and its framing flags
//   sel               row currently being drained
//   busy              frame in progress (state != IDLE)
//   frame_done        one-cycle pulse after the eop word is accepted

// Per-row pop strobe: the shared pop decision is steered to the row that
// matches the current selection.
module huffman_row_scheduler_lane #(
  parameter int LANE  = 0,
  parameter int SEL_W = 2
) (
  input  logic             pop,
  input  logic [SEL_W-1:0] sel,
  output logic             rd
);
  assign rd = pop & (sel == SEL_W'(LANE));
endmodule

module huffman_row_scheduler #(
  parameter  int ROW    = 3,
  parameter  int DATA_W = 71,
  parameter  int BLK_W  = 16,
  localparam int SEL_W  = $clog2(ROW)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [BLK_W-1:0]           blocks_per_row,
  input  logic [ROW-1:0]             ch_empty,
  input  logic [ROW-1:0][DATA_W-1:0] ch_data,
  input  logic [ROW-1:0]             ch_last,
  output logic [ROW-1:0]             ch_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [SEL_W-1:0]           sel,
  output logic                       busy,
  output logic                       frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [BLK_W-1:0] blk_target;
  logic [BLK_W-1:0] blk_cnt;
  logic             first_pending;

  logic             start_ok;
  logic             pop;
  logic             drain_ok;
  logic             out_free;
  logic             sel_last;
  logic             blk_last;
  logic             eop_w;

  // Output register can take a new word when empty or being emptied this cycle.
  assign out_free = ~out_valid | out_ready;
  assign sel_last = (sel == SEL_W'(ROW - 1));
  assign blk_last = (blk_cnt == blk_target - 1'b1);
  assign eop_w    = ch_last[sel] & sel_last & blk_last;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)     state_nxt = RUN;
      RUN:     if (pop && eop_w) state_nxt = DRAIN;
      DRAIN:   if (drain_ok)     state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    start_ok = (state == IDLE) & start & (|blocks_per_row);
    // An empty selected row stalls everything; other rows are never touched.
    pop      = (state == RUN) & ~ch_empty[sel] & out_free;
    drain_ok = (state == DRAIN) & out_free;
  end

  // ---------------------------------------------------------- pop steering
  for (genvar g = 0; g < ROW; g++) begin : g_lane
    huffman_row_scheduler_lane #(
      .LANE  (g),
      .SEL_W (SEL_W)
    ) u_lane (
      .pop (pop),
      .sel (sel),
      .rd  (ch_rd[g])
    );
  end

  // ---------------------------------------------- sequencing and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_target    <= '0;
      blk_cnt       <= '0;
      sel           <= '0;
      first_pending <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= drain_ok;

      if (start_ok) begin
        blk_target    <= blocks_per_row;
        blk_cnt       <= '0;
        sel           <= '0;
        first_pending <= 1'b1;
      end

      if (pop) begin
        // A pop in the same cycle as the downstream handshake replaces the
        // register contents directly, so there is no bubble.
        out_valid     <= 1'b1;
        out_data      <= ch_data[sel];
        out_last      <= ch_last[sel];
        out_sop       <= first_pending;
        out_eop       <= eop_w;
        first_pending <= 1'b0;
        // Block boundary: move to the next row; wrapping past the last row
        // completes one round of blocks.
        if (ch_last[sel]) begin
          if (sel_last) begin
            sel     <= '0;
            blk_cnt <= blk_cnt + 1'b1;
          end else begin
            sel <= sel + 1'b1;
          end
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
